// File: rtl/stream_demux.sv
// stream_demux: valid/ready demultiplexer that routes each input beat to one of N
// registered one-entry channel stages, chosen by the beat's in_sel field.
// Ports: clk, rst (async, active-high), flush (sync clear of all stage valids),
//   in_valid/in_ready/in_data/in_sel (shared input stream),
//   out_valid/out_ready/out_data (per-channel streams, channel i at out_data[i*WIDTH +: WIDTH]),
//   err_pulse/err_count (out-of-range beat discarded; count saturates at 255).
module stream_demux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SELW-1:0]    in_sel,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               err_pulse,
    output logic [7:0]         err_count
);
    logic [N-1:0]            sel_oh;
    logic                    accept;
    logic [N-1:0]            v_q, v_d;
    logic [N-1:0][WIDTH-1:0] d_q, d_d;
    logic                    err_q, err_d;
    logic [7:0]              cnt_q, cnt_d;
    // An out-of-range select decodes to an all-zero one-hot, which both frees
    // in_ready from any channel and marks the beat for discard.
    always_comb begin
        for (int i = 0; i < N; i++) sel_oh[i] = int'(in_sel) == i;
    end
    assign in_ready = !rst && !flush && ~|(sel_oh & v_q & ~out_ready);
    assign accept   = in_valid && in_ready;
    // A fill on the same edge as a drain overrides it, so the new beat replaces the old.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            v_d[i] = flush ? 1'b0 : (accept && sel_oh[i]) ? 1'b1 : v_q[i] && !out_ready[i];
            d_d[i] = (accept && sel_oh[i]) ? in_data : d_q[i];
        end
        err_d = accept && ~|sel_oh;
        cnt_d = (err_d && cnt_q != 8'hff) ? cnt_q + 8'd1 : cnt_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            d_q   <= '0;
            err_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            v_q   <= v_d;
            d_q   <= d_d;
            err_q <= err_d;
            cnt_q <= cnt_d;
        end
    end
    assign out_valid = v_q;
    assign out_data  = d_q;
    assign err_pulse = err_q;
    assign err_count = cnt_q;
endmodule

// File: tb/tb_stream_demux.sv
// tb_stream_demux: table, directed and randomized checks of stream_demux at N=4 and N=3.
module tb_stream_demux;
    logic         clk, rst, flush, in_valid;
    logic [31:0]  in_data;
    logic [1:0]   in_sel;
    logic [3:0]   out_ready;
    logic         rdy4, rdy3, ep4, ep3;
    logic [3:0]   ov4;
    logic [2:0]   ov3;
    logic [127:0] od4;
    logic [95:0]  od3;
    logic [7:0]   ec4, ec3;
    int n_chk = 0;
    int n_fail = 0;

    stream_demux #(.WIDTH(32), .N(4)) u4 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy4),
        .in_data(in_data), .in_sel(in_sel), .out_valid(ov4), .out_ready(out_ready),
        .out_data(od4), .err_pulse(ep4), .err_count(ec4)
    );
    stream_demux #(.WIDTH(32), .N(3)) u3 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy3),
        .in_data(in_data), .in_sel(in_sel), .out_valid(ov3), .out_ready(out_ready[2:0]),
        .out_data(od3), .err_pulse(ep3), .err_count(ec3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             vl;
        logic [1:0]       sel;
        logic [31:0]      dat;
        logic [3:0]       ordy;
        logic             e_rdy;
        logic [3:0]       e_ov;
        logic [3:0][31:0] e_d;
    } vec_t;

    typedef struct {
        int          ch;
        logic [31:0] d;
    } beat_t;

    vec_t  tbl[$];
    beat_t pend[$];

    function automatic vec_t mk(logic vl, logic [1:0] sel, logic [31:0] dat, logic [3:0] ordy,
                                logic e_rdy, logic [3:0] e_ov,
                                logic [31:0] d0, logic [31:0] d1, logic [31:0] d2, logic [31:0] d3);
        vec_t r;
        r.vl = vl; r.sel = sel; r.dat = dat; r.ordy = ordy;
        r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_d = {d3, d2, d1, d0};
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vl, input logic [1:0] sel, input logic [31:0] dat);
        in_valid = vl; in_sel = sel; in_data = dat;
    endtask

    initial begin
        logic [127:0] mask;
        logic [95:0]  mask3, exp_d3;
        logic [2:0]   exp_ov3;
        logic         exp_rdy, e_pulse, acc, found;
        int           e_cnt;

        // reset state
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1; in_sel = 2'd0; in_data = '0; out_ready = '1;
        @(negedge clk);
        chk("reset_in_ready", rdy4, 1'b0);
        chk("reset_out_valid", ov4, 4'b0);
        chk("reset_out_data", od4, 128'b0);
        chk("reset_err", {ep3, ec3}, 9'b0);
        do_reset();

        // routing, stall isolation and fill-while-drain on N=4
        tbl.push_back(mk(1, 0, 32'hA0, 4'hF, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 1, 32'hA1, 4'hF, 1, 4'b0001, 32'hA0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 32'hA2, 4'hF, 1, 4'b0010, 0, 32'hA1, 0, 0));
        tbl.push_back(mk(1, 3, 32'hA3, 4'hF, 1, 4'b0100, 0, 0, 32'hA2, 0));
        tbl.push_back(mk(0, 0, 0,      4'hF, 1, 4'b1000, 0, 0, 0, 32'hA3));
        tbl.push_back(mk(0, 0, 0,      4'hF, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 32'h11, 4'hB, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 2, 32'h22, 4'hB, 0, 4'b0100, 0, 0, 32'h11, 0));
        tbl.push_back(mk(1, 1, 32'h33, 4'hB, 1, 4'b0100, 0, 0, 32'h11, 0));
        tbl.push_back(mk(0, 0, 0,      4'hB, 1, 4'b0110, 0, 32'h33, 32'h11, 0));
        tbl.push_back(mk(1, 2, 32'h22, 4'hF, 1, 4'b0100, 0, 0, 32'h11, 0));
        tbl.push_back(mk(0, 0, 0,      4'hF, 1, 4'b0100, 0, 0, 32'h22, 0));
        tbl.push_back(mk(0, 0, 0,      4'hF, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h55, 4'hF, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(mk(1, 0, 32'h66, 4'hF, 1, 4'b0001, 32'h55, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,      4'hF, 1, 4'b0001, 32'h66, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0,      4'hF, 1, 4'b0000, 0, 0, 0, 0));
        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].vl, tbl[r].sel, tbl[r].dat);
            out_ready = tbl[r].ordy;
            @(negedge clk);
            for (int i = 0; i < 4; i++) mask[i*32 +: 32] = {32{tbl[r].e_ov[i]}};
            chk($sformatf("tbl%0d_in_ready", r), rdy4, tbl[r].e_rdy);
            chk($sformatf("tbl%0d_out_valid", r), ov4, tbl[r].e_ov);
            chk($sformatf("tbl%0d_out_data", r), od4 & mask, tbl[r].e_d & mask);
            cyc();
        end

        // out-of-range beats on N=3 saturate the error counter
        do_reset();
        drive(1, 2'd3, 0);
        for (int k = 0; k < 300; k++) begin
            in_data = k;
            @(negedge clk);
            chk("oor_in_ready", rdy3, 1'b1);
            chk("oor_out_valid", ov3, 3'b0);
            chk("oor_err_pulse", ep3, k > 0);
            chk("oor_err_count", ec3, (k > 255) ? 255 : k);
            cyc();
        end
        drive(0, 0, 0);
        @(negedge clk);
        chk("oor_last_pulse", ep3, 1'b1);
        chk("oor_sat", ec3, 8'd255);
        cyc();
        @(negedge clk);
        chk("oor_pulse_off", ep3, 1'b0);
        chk("oor_hold", ec3, 8'd255);
        chk("pow2_err_count", ec4, 8'd0);

        // flush while channels 0 and 3 stall
        do_reset();
        drive(1, 0, 32'hC0);
        cyc();
        drive(1, 3, 32'hC3);
        cyc();
        drive(1, 1, 32'hC1);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", rdy4, 1'b0);
        chk("flush_pre_valid", ov4, 4'b1001);
        chk("flush_pre_count", ec3, 8'd1);
        cyc();
        flush = 1'b0;
        drive(0, 0, 0);
        @(negedge clk);
        chk("flush_out_valid", ov4, 4'b0);
        chk("flush_data_kept", od4[31:0], 32'hC0);
        chk("flush_count_kept", ec3, 8'd1);
        chk("flush_pulse_clr", ep3, 1'b0);
        cyc();

        // asynchronous reset between edges
        do_reset();
        drive(1, 3, 32'hD3);
        cyc();
        drive(1, 1, 32'hB1);
        cyc();
        drive(1, 2, 32'hB2);
        cyc();
        drive(1, 0, 32'hB0);
        @(negedge clk);
        chk("arst_pre_valid", ov4, 4'b1110);
        chk("arst_pre_count", ec3, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_out_valid", ov4, 4'b0);
        chk("arst_out_data", od4, 128'b0);
        chk("arst_err_count", ec3, 8'd0);
        chk("arst_in_ready", {rdy4, rdy3}, 2'b00);
        @(posedge clk);
        @(negedge clk);
        chk("arst_held_ready", rdy4, 1'b0);
        rst = 1'b0;
        #1;
        chk("arst_release_ready", rdy4, 1'b1);
        cyc();

        // randomized traffic on N=3 against a pending-beat scoreboard
        do_reset();
        e_cnt = 0;
        e_pulse = 1'b0;
        pend.delete();
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            in_sel    = 2'($urandom_range(0, 3));
            in_data   = $urandom;
            out_ready = 4'($urandom);
            flush     = ($urandom_range(0, 19) == 0);
            @(negedge clk);
            exp_ov3 = '0;
            exp_d3  = '0;
            mask3   = '0;
            foreach (pend[j]) begin
                exp_ov3[pend[j].ch] = 1'b1;
                exp_d3[pend[j].ch*32 +: 32] = pend[j].d;
                mask3[pend[j].ch*32 +: 32] = '1;
            end
            found = 1'b0;
            foreach (pend[j]) if (pend[j].ch == int'(in_sel)) found = 1'b1;
            exp_rdy = !flush && (!found || out_ready[in_sel]);
            chk("rnd_in_ready", rdy3, exp_rdy);
            chk("rnd_out_valid", ov3, exp_ov3);
            chk("rnd_out_data", od3 & mask3, exp_d3);
            chk("rnd_err_pulse", ep3, e_pulse);
            chk("rnd_err_count", ec3, e_cnt);
            if (flush) begin
                pend.delete();
                e_pulse = 1'b0;
            end else begin
                acc = in_valid && exp_rdy;
                for (int j = pend.size() - 1; j >= 0; j--)
                    if (out_ready[pend[j].ch]) pend.delete(j);
                if (acc && in_sel < 3) pend.push_back('{int'(in_sel), in_data});
                e_pulse = acc && in_sel == 3;
                if (e_pulse && e_cnt < 255) e_cnt++;
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/stream_demux.md
Name: stream_demux

Overview:
Valid/ready stream demultiplexer that routes each beat of one input stream to one of N output channels, chosen by a per-beat select field. Each output channel has its own one-entry registered holding stage, so a stalled consumer blocks only beats addressed to that consumer. It sits between a shared producer, such as a decode or writeback bus, and per-unit consumer queues. It is the sequential counterpart of the team's combinational demux and mux blocks.

Parameters:
WIDTH, 32, data width of a beat
N, 4, number of output channels (>=2; need not be a power of 2)
SELW, $clog2(N), select width (derived; do not override)

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
flush  input  1  synchronous clear of all channel stages
in_valid  input  1  input beat valid
in_ready  output  1  input beat accepted when in_valid && in_ready
in_data  input  WIDTH  input beat payload
in_sel  input  SELW  destination channel index
out_valid  output  N  per-channel valid, bit i = channel i
out_ready  input  N  per-channel ready, bit i = channel i
out_data  output  N*WIDTH  channel i payload at bits [i*WIDTH +: WIDTH]
err_pulse  output  1  one-cycle pulse: an out-of-range beat was discarded
err_count  output  8  saturating count of discarded beats

Behaviour:
- Clock and reset: single clock domain. rst is asynchronous and active-high.
- Reset values: all out_valid = 0, all out_data = 0, err_pulse = 0, err_count = 0. While rst is asserted, in_ready = 0.
- Reset mid-operation: asserting rst clears every output immediately, without waiting for a clock edge. Held beats are lost.
- Channel stage: each channel i holds one register pair, v[i] and d[i]. out_valid[i] = v[i] and out_data slice i = d[i].
- Input ready, in range (in_sel < N): in_ready = !flush && (!v[in_sel] || out_ready[in_sel]). This is a combinational path from out_ready to in_ready, and it is permitted.
- Input ready, out of range (in_sel >= N): in_ready = !flush.
- Accept, in range: the beat is written at the clock edge. d[in_sel] <= in_data and v[in_sel] <= 1.
- Latency: exactly 1 cycle from accept to out_valid.
- Throughput: 1 beat/cycle to any channel, including back-to-back beats to the same channel while its consumer holds out_ready = 1.
- Drain: if v[i] && out_ready[i] and channel i is not written this cycle, then v[i] <= 0 and d[i] holds its value.
- Simultaneous drain and fill on the same channel: the new beat replaces the old one (v stays 1). No beat is lost or duplicated.
- Stall: while v[i] && !out_ready[i], d[i] and v[i] are held stable. Beats addressed to channel i are refused. Beats to other channels proceed unaffected.
- Isolation: only the selected channel's stage is written. Every other channel holds or drains independently.
- Out-of-range accept (in_sel >= N, only possible when N is not a power of 2): the beat is discarded and no channel changes.
  - err_pulse = 1 in the following cycle.
  - err_count increments, saturating at 255.
- flush (synchronous): at the edge, all v <= 0. d is unchanged, err_count is unchanged, err_pulse <= 0.
  - in_ready = 0 during flush, so no beat is accepted in a flush cycle.
  - flush has priority over drain and fill.
- Output protocol: once out_valid[i] rises, it stays high with stable data until out_ready[i] is sampled high, or until flush or rst.
- Input protocol: in_valid does not need to wait for in_ready. in_data and in_sel are only meaningful when in_valid = 1.
- Out-of-range select with N a power of 2: this case cannot occur. err_count stays 0.

Test Plan:
1. Basic routing: N=4, all out_ready=1. Send beats 0xA0 to sel 0, 0xA1 to sel 1, 0xA2 to sel 2, 0xA3 to sel 3 on consecutive cycles. Required: each appears on its channel exactly 1 cycle after accept. in_ready stays 1 throughout, and only one out_valid bit is high per cycle.
2. Stall isolation: out_ready[2]=0. Send 0x11 to sel 2, then 0x22 to sel 2, then 0x33 to sel 1. Required: 0x11 is held on channel 2. in_ready = 0 while 0x22 is presented. After 0x22 is withdrawn, 0x33 is accepted and appears on channel 1. Then raise out_ready[2]: 0x11 drains, 0x22 is accepted next, and channel 2 outputs 0x22 one cycle later.
3. Fill-while-drain: channel 0 holds 0x55 with out_ready[0]=1. Present 0x66 to sel 0 in the same cycle. Required: in_ready = 1, the consumer sees 0x55 then 0x66 on consecutive cycles, and out_valid[0] never drops between them.
4. Out-of-range, N=3: send a beat with sel=3, 300 times. Required: beats are accepted and no out_valid asserts. err_pulse is high for 1 cycle after each accept. err_count reaches and holds at 255.
5. Flush: channels 0 and 3 are valid and stalled, and in_valid=1 to sel 1 with flush=1 for one cycle. Required: in_ready = 0 that cycle. Next cycle all out_valid = 0, and err_count is unchanged.
6. Async reset: assert rst between clock edges while channels 1 and 2 are valid. Required: out_valid = 0, out_data = 0, and err_count = 0 before the next edge. in_ready = 0 until rst is released.
